mips_muldiv_sequencer: RTL
==========================

// Module: mips_muldiv_sequencer
// PURPOSE
//  Multi-cycle controller for MULT/MULTU/DIV/DIVU. Replaces the single-cycle combinational multiplier/divider
//  feeding the HI/LO registers with an iterative shift-add / restoring-divide engine.
//  Produces hi/lo data and hi_write/lo_write strobes for the HI/LO register block.
//  Raises a stall for the main controller while an operation is in flight.
// PARAMETERS
//  DATA_WIDTH  32  operand / HI / LO width
//  CNT_WIDTH   6   iteration counter width; must hold DATA_WIDTH
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  start       in   1   launch op; accepted only when busy=0
//  op          in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  operand_a   in   32  rs value (multiplicand / dividend); sampled with start
//  operand_b   in   32  rt value (multiplier / divisor); sampled with start
//  cancel      in   1   flush: abort in-flight op, no HI/LO write
//  hilo_read   in   1   decode stage holds MFHI/MFLO
//  busy        out  1   high in every state except IDLE
//  stall       out  1   busy & (hilo_read | start)
//  done        out  1   1-cycle pulse in DONE
//  div_zero    out  1   1-cycle pulse with done when divisor was 0
//  hi_out      out  32  HI result, valid when done=1
//  lo_out      out  32  LO result, valid when done=1
//  hi_write    out  1   equals done
//  lo_write    out  1   equals done
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy, done, div_zero, hi_write, lo_write = 0; hi_out, lo_out, counter = 0.
//  - FSM: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
//  - IDLE: start=1 latches op and operands; next state PREP.
//  - PREP (1 cycle): signed ops take |a| and |b|; record sign_q = a[31]^b[31], sign_r = a[31]; counter=0.
//    Divide with b==0 goes straight to DONE: LO=32'hFFFF_FFFF, HI=operand_a, div_zero=1.
//  - RUN (32 cycles): one radix-2 step per cycle; counter increments; after count 31 go to FIX.
//    - Multiply: 64-bit {acc,mplr} shift-add.
//    - Divide: restoring; {rem,quot} shift-left, subtract divisor when no borrow, quotient bit = !borrow.
//  - FIX (1 cycle) — sign correction:
//    - MULT: negate 64-bit product if sign_q.
//    - DIV: negate quotient if sign_q; negate remainder if sign_r.
//    - Remainder sign follows dividend; arithmetic is modulo 2^32 / 2^64.
//    - -2^31 / -1 gives LO=32'h8000_0000, HI=0 without special casing.
//  - DONE (1 cycle): done=hi_write=lo_write=1, hi_out/lo_out valid; next IDLE.
//  - Latency: start sampled at edge E0 -> done high in the cycle after edge E34, i.e. 35 cycles, fixed.
//    b==0 divide: done after edge E2.
//  - Start while busy: ignored, not queued; stall stays high until IDLE.
//  - cancel: any non-IDLE state -> IDLE at next edge. No done, no writes.
//    cancel and start together in IDLE: cancel wins, start dropped.
//  - hi_out/lo_out hold their last values after DONE until the next DONE.
//  - Back-to-back: start in the cycle after DONE is accepted (state is IDLE).
//  - rst mid-operation: immediate IDLE; the partial result is discarded.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//    - Multiply RUN exits to FIX as soon as the remaining multiplier bits are all zero (minimum 1 RUN cycle).
//    - Latency = 4 + index of highest set bit of |b|, +1. E.g. MULTU x*1 -> done after edge E4.
//    - Divide latency unchanged.
//  MULDIV_EARLY_OUT_EN undefined: all operations use the fixed 35-cycle latency.
// TESTING
//  1. MULT a=-3 (FFFFFFFD), b=7 -> done after E34; HI=FFFFFFFF, LO=FFFFFFEB; busy high exactly 35 cycles.
//  2. MULTU a=FFFFFFFF, b=FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
//  3. DIVU 100/7 -> LO=14, HI=2.
//     DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//     DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
//  4. DIV 5/0 -> done after E2; div_zero=1, LO=FFFFFFFF, HI=5.
//  5. start at cycle 10 of DIVU 100/7 with 9/3 -> ignored; result stays LO=14.
//     hilo_read=1 while busy -> stall=1.
//     Second start in the cycle after DONE -> accepted.
//  6. cancel at RUN cycle 5 -> IDLE next edge, no done/hi_write; rst pulse mid-RUN -> all outputs 0 asynchronously.
//     With MULDIV_EARLY_OUT_EN: MULTU 9*1 -> LO=9, done after E4.

Source files
------------

// File: rtl/mips_muldiv_sequencer_if.sv
// Handshake and result bundle between the main controller and the MULT/DIV sequencer.
interface mips_muldiv_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  cancel;
    logic                  hilo_read;
    logic                  busy;
    logic                  stall;
    logic                  done;
    logic                  div_zero;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;
    logic                  hi_write;
    logic                  lo_write;

    modport master (
        output start, op, operand_a, operand_b, cancel, hilo_read,
        input  busy, stall, done, div_zero, hi_out, lo_out, hi_write, lo_write
    );

    modport slave (
        input  start, op, operand_a, operand_b, cancel, hilo_read,
        output busy, stall, done, div_zero, hi_out, lo_out, hi_write, lo_write
    );
endinterface

// File: rtl/mips_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine driving the HI/LO register block.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves RUN once the remaining multiplier bits are zero.
module mips_muldiv_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    mips_muldiv_sequencer_if.slave  bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] x,
                                                      input logic is_signed);
        if (is_signed && x[DATA_WIDTH-1]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    logic [2:0]           state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d;
    logic [W-1:0]         mplr_q, mplr_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic [2*W-1:0]       aux_q, aux_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 neg_prod_q, neg_prod_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dz_out_q, dz_out_d;
    logic                 busy_q, busy_d;

    logic                 is_signed_s, is_div_s, rem_ge_s, run_exit_s;
    logic [W-1:0]         abs_a_s, abs_b_s, quot_fix_s, rem_fix_s;
    logic [W:0]           rem_sh_s, rem_sub_s;
    logic [2*W-1:0]       prod_fix_s;

    // Datapath helpers: operand magnitudes, restoring-divide step, sign correction.
    always_comb begin
        is_signed_s = ~op_q[0];
        is_div_s    = op_q[1];
        abs_a_s     = abs_val(a_q, is_signed_s);
        abs_b_s     = abs_val(b_q, is_signed_s);
        rem_sh_s    = {acc_q[2*W-1:W], acc_q[W-1]};
        rem_ge_s    = (rem_sh_s >= {1'b0, aux_q[W-1:0]});
        rem_sub_s   = rem_sh_s - {1'b0, aux_q[W-1:0]};
        prod_fix_s  = neg_prod_q ? -acc_q : acc_q;
        quot_fix_s  = neg_prod_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix_s   = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        mplr_d     = mplr_q;
        acc_d      = acc_q;
        aux_d      = aux_q;
        cnt_d      = cnt_q;
        neg_prod_d = neg_prod_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dz_out_d   = 1'b0;
        run_exit_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    op_d    = bus.op;
                    a_d     = bus.operand_a;
                    b_d     = bus.operand_b;
                    state_d = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                neg_prod_d = is_signed_s & (a_q[W-1] ^ b_q[W-1]);
                neg_rem_d  = is_signed_s & a_q[W-1];
                cnt_d      = {CNT_WIDTH{1'b0}};
                dz_d       = is_div_s && (b_q == {W{1'b0}});
                if (is_div_s && (b_q == {W{1'b0}})) begin
                    // Zero divisor passes through FIX untouched so done lands after E2.
                    acc_d   = {a_q, {W{1'b1}}};
                    state_d = S_FIX;
                end else if (is_div_s) begin
                    acc_d   = {{W{1'b0}}, abs_a_s};
                    aux_d   = {{W{1'b0}}, abs_b_s};
                    state_d = S_RUN;
                end else begin
                    acc_d   = {2*W{1'b0}};
                    aux_d   = {{W{1'b0}}, abs_a_s};
                    mplr_d  = abs_b_s;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (is_div_s) begin
                    acc_d = {(rem_ge_s ? rem_sub_s[W-1:0] : rem_sh_s[W-1:0]),
                             acc_q[W-2:0], rem_ge_s};
                end else begin
                    // Multiplicand shifts left so the product stays aligned on an early exit.
                    acc_d  = mplr_q[0] ? (acc_q + aux_q) : acc_q;
                    aux_d  = {aux_q[2*W-2:0], 1'b0};
                    mplr_d = {1'b0, mplr_q[W-1:1]};
                end
`ifdef MULDIV_EARLY_OUT_EN
                run_exit_s = (cnt_q == CNT_LAST) || (!is_div_s && (mplr_q == {W{1'b0}}));
`else
                run_exit_s = (cnt_q == CNT_LAST);
`endif
                if (run_exit_s) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    hi_d = acc_q[2*W-1:W];
                    lo_d = acc_q[W-1:0];
                end else if (is_div_s) begin
                    hi_d = rem_fix_s;
                    lo_d = quot_fix_s;
                end else begin
                    hi_d = prod_fix_s[2*W-1:W];
                    lo_d = prod_fix_s[W-1:0];
                end
                done_d   = 1'b1;
                dz_out_d = dz_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus.cancel && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            dz_out_d = 1'b0;
            hi_d     = hi_q;
            lo_d     = lo_q;
        end else begin
            state_d  = state_d;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            a_q        <= {W{1'b0}};
            b_q        <= {W{1'b0}};
            mplr_q     <= {W{1'b0}};
            acc_q      <= {2*W{1'b0}};
            aux_q      <= {2*W{1'b0}};
            cnt_q      <= {CNT_WIDTH{1'b0}};
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= {W{1'b0}};
            lo_q       <= {W{1'b0}};
            done_q     <= 1'b0;
            dz_out_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mplr_q     <= mplr_d;
            acc_q      <= acc_d;
            aux_q      <= aux_d;
            cnt_q      <= cnt_d;
            neg_prod_q <= neg_prod_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dz_out_q   <= dz_out_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.stall    = busy_q & (bus.hilo_read | bus.start);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_out_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.hi_write = done_q;
    assign bus.lo_write = done_q;
endmodule
